gaten_filt: RTL
===============

# gaten_filt

Parametrised N-input registered logic gate for the Unisims library. It generalises the fixed inverted-input gate primitives in three ways: configurable input width, a per-input inversion mask, and runtime function selection. The output is registered and passes through a consecutive-cycle stability filter. It sits in the same primitive layer as the combinational gates, for use where a glitch-free, clocked gate output is needed, e.g. qualifying asynchronous status lines.

## Interface
- WIDTH, 3: number of gate inputs; legal 2..16.
- INV_MASK, {WIDTH{1'b1}}: bit i set inverts I[i] before the gate function.
- INIT, 1'b0: value of O after reset.
- FILTER, 0: extra consecutive cycles the new gate result must persist before O changes; legal 0..255.
- REG_IN, 1: 1 adds an input capture register on I; 0 feeds I directly.

- C  input  1  clock, rising edge.
- R  input  1  reset; synchronous, active-high.
- CE  input  1  clock enable for all state except reset.
- MODE  input  3  gate function: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR; 110/111 reserved (hold).
- I  input  WIDTH  gate inputs.
- O  output  1  filtered, registered gate output.
- CHG  output  1  one-cycle pulse on the edge where O toggles.

## Operation
- Input stage: REG_IN=1 gives i_q <= I on each CE edge. REG_IN=0 gives i_q = I (wire).
- Masking: x = i_q ^ INV_MASK.
- Reduction: raw = f_MODE(x). XOR/XNOR are the parity of all WIDTH bits. Reserved MODE forces raw = O, so there is no change and the counter clears.
- Filter state: counter cnt, width $clog2(FILTER+1), minimum 1 bit.
- On each CE edge:
  - If raw == O: cnt <= 0, O holds, CHG <= 0.
  - If raw != O and cnt == FILTER: O <= raw, cnt <= 0, CHG <= 1.
  - If raw != O and cnt < FILTER: cnt <= cnt+1, CHG <= 0.
- A raw pulse shorter than FILTER+1 CE cycles never reaches O. A bounce back to O mid-count restarts the count from 0.
- CE low: i_q, cnt and O hold; CHG <= 0. Cycles with CE low do not count toward FILTER.
- MODE is not registered. A change takes effect on raw in the same cycle and is subject to the filter like any input change.
- Reset (R=1 at an edge, priority over CE): O <= INIT, CHG <= 0, cnt <= 0, i_q <= 0. Reset mid-count discards the count.
- Reset values: O=INIT, CHG=0.

## Timing
- Latency from I change (held stable, CE=1) to O change is REG_IN + FILTER + 1 edges. With defaults (REG_IN=1, FILTER=0) this is 2 edges.
- Latency from a MODE change to O is FILTER + 1 edges.
- CHG is asserted in the same cycle O first shows its new value, for exactly one cycle.
- All outputs come straight from flops; there is no combinational path from I, MODE or CE to O or CHG.
- Timescale is 100 ps / 10 ps, matching the library. No specify block is needed because all paths are clocked.

## Structure
- Shared package gaten_pkg:
  - MODE encodings as localparams: MODE_AND, MODE_NAND, MODE_OR, MODE_NOR, MODE_XOR, MODE_XNOR.
  - Function gate_reduce(mode, x), returning raw.
- Sub-module stable_filt, parameters FILTER and INIT, ports C, R, CE, D, Q, CHG. It holds the counter and the output flop.
- gaten_filt contains the input register, masking, gate_reduce and one stable_filt instance.
- Elaboration-time checks on WIDTH, FILTER range and INV_MASK width; out-of-range values are a fatal error.

## Test plan
- Reset: WIDTH=3, INIT=1, R=1 for 2 edges with I=3'b101 -> O=1, CHG=0 throughout. After R drops, O settles to NAND of inverted inputs (~(0&1&0)=1) with no CHG pulse.
- Default config (NAND3B3 equivalent, FILTER=0): sweep all 8 values of I -> O = ~(~I0 & ~I1 & ~I2), 2 edges after each change. CHG pulses only when O toggles, i.e. at I=000.
- Filter: WIDTH=4, INV_MASK=0, MODE=AND, FILTER=3, REG_IN=0.
  - I=1111 held 3 edges, then 0000 -> O stays 0, CHG never asserts.
  - I=1111 held 4 edges -> O=1 on the 4th edge, with a single CHG pulse.
- Bounce restart: same config. I=1111 for 2 edges, 0000 for 1 edge, 1111 for 4 edges -> O rises exactly 4 edges after the last rising edge of I.
- CE gating: FILTER=2. Assert raw change with CE pattern 1,0,0,1,1 -> O changes on the 3rd CE-high edge. CHG is 0 during CE-low cycles.
- MODE and reset mid-operation:
  - WIDTH=5, I=5'b10110, MODE XOR -> XNOR -> O toggles FILTER+1 edges later.
  - MODE=111 -> O holds indefinitely.
  - R asserted with cnt=FILTER-1 -> O=INIT and cnt=0 on the next edge.

Source files
------------

// File: rtl/gaten_pkg.sv
`timescale 100ps/10ps
// Shared definitions for the registered N-input gate primitives.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package gaten_pkg;

    localparam logic [2:0] MODE_AND  = 3'b000;
    localparam logic [2:0] MODE_NAND = 3'b001;
    localparam logic [2:0] MODE_OR   = 3'b010;
    localparam logic [2:0] MODE_NOR  = 3'b011;
    localparam logic [2:0] MODE_XOR  = 3'b100;
    localparam logic [2:0] MODE_XNOR = 3'b101;

    // Widest gate supported; narrower gates zero-extend into this.
    localparam int MAX_WIDTH = 16;

    // Reduce the low n bits of x with the selected function.
    // Reserved encodings return hold so the caller sees no change.
    function automatic logic gate_reduce(input logic [2:0]           mode,
                                         input logic [MAX_WIDTH-1:0] x,
                                         input int                   n,
                                         input logic                 hold);
        logic all_one;
        logic any_one;
        logic parity;
        all_one = 1'b1;
        any_one = 1'b0;
        parity  = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < n) begin
                all_one = all_one & x[i];
                any_one = any_one | x[i];
                parity  = parity ^ x[i];
            end
        end
        case (mode)
            MODE_AND:  return all_one;
            MODE_NAND: return ~all_one;
            MODE_OR:   return any_one;
            MODE_NOR:  return ~any_one;
            MODE_XOR:  return parity;
            MODE_XNOR: return ~parity;
            default:   return hold;
        endcase
    endfunction

endpackage

// File: rtl/gaten_stable_filt.sv
`timescale 100ps/10ps
// Consecutive-cycle stability filter: Q follows D once D has differed for FILTER+1 CE edges.
// Latency: FILTER+1 CE-high edges from a persistent D change to Q; CHG in the same cycle.
// Backpressure: none; CE low freezes the count and Q, CHG drops to 0.
module stable_filt #(
    parameter int   FILTER = 0,
    parameter logic INIT   = 1'b0
) (
    input  logic C,
    input  logic R,
    input  logic CE,
    input  logic D,
    output logic Q,
    output logic CHG
);

    localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    logic [CW-1:0] cnt;

    // Count CE edges on which D disagrees with Q; any agreement restarts the count.
    always_ff @(posedge C) begin
        if (R) begin
            Q   <= INIT;
            CHG <= 1'b0;
            cnt <= '0;
        end else if (CE) begin
            if (D == Q) begin
                cnt <= '0;
                CHG <= 1'b0;
            end else if (cnt == CNT_MAX) begin
                Q   <= D;
                cnt <= '0;
                CHG <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
                CHG <= 1'b0;
            end
        end else begin
            CHG <= 1'b0;
        end
    end

endmodule

// File: rtl/gaten_filt.sv
`timescale 100ps/10ps
// Parametrised N-input gate with per-input inversion, runtime function select and filtered registered output.
// Latency: REG_IN+FILTER+1 CE edges from a held input change to O (FILTER+1 from a MODE change).
// Backpressure: none; CE low holds all state and forces CHG low.
module gaten_filt
    import gaten_pkg::*;
#(
    parameter int   WIDTH    = 3,
    parameter       INV_MASK = {WIDTH{1'b1}},
    parameter logic INIT     = 1'b0,
    parameter int   FILTER   = 0,
    parameter int   REG_IN   = 1
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] I,
    output logic             O,
    output logic             CHG
);

    // Reject illegal configurations at elaboration.
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "gaten_filt: WIDTH must be 2..16");
    end
    if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
        $fatal(1, "gaten_filt: FILTER must be 0..255");
    end
    if ((INV_MASK >> WIDTH) != 0) begin : g_bad_mask
        $fatal(1, "gaten_filt: INV_MASK wider than WIDTH");
    end
    if (REG_IN != 0 && REG_IN != 1) begin : g_bad_reg_in
        $fatal(1, "gaten_filt: REG_IN must be 0 or 1");
    end

    localparam logic [WIDTH-1:0] MASK = WIDTH'(INV_MASK);

    logic [WIDTH-1:0] i_q;
    logic [WIDTH-1:0] x;
    logic             raw;

    if (REG_IN != 0) begin : g_reg_in
        // Capture the inputs so asynchronous status lines get one register stage.
        always_ff @(posedge C) begin
            if (R) begin
                i_q <= '0;
            end else if (CE) begin
                i_q <= I;
            end
        end
    end else begin : g_wire_in
        assign i_q = I;
    end

    assign x = i_q ^ MASK;

    // Gate result; reserved modes echo O so the filter sees no change.
    always_comb begin
        raw = gate_reduce(MODE, MAX_WIDTH'(x), WIDTH, O);
    end

    stable_filt #(
        .FILTER (FILTER),
        .INIT   (INIT)
    ) u_filt (
        .C   (C),
        .R   (R),
        .CE  (CE),
        .D   (raw),
        .Q   (O),
        .CHG (CHG)
    );

endmodule
